// File: rtl/minterm_table_scanner.sv
// minterm_table_scanner
// ---------------------
// Walks every input combination of two N_IN-input Boolean functions. Each
// function is given as a minterm mask: bit m of the mask is f(m). The block
// streams the truth table one row per valid/ready handshake. While it scans,
// it accumulates the minterm count of A and the A-vs-B mismatch statistics.
// At the end it reports equivalence and whether A is constant.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            begin a scan (honoured in IDLE and DONE only)
//   mask_a, mask_b   minterm masks of function A (expression form) and
//                    function B (gate-level form)
//   busy             scan in progress
//   row_valid        current truth-table row is presented
//   row_ready        consumer accepts the presented row
//   row_m            minterm index of the current row, MSB = first input
//   row_fa, row_fb   function values of the current row
//   row_mismatch     row_fa ^ row_fb
//   done             one-cycle pulse after the final row has transferred
//   ones_a           number of minterms of A
//   mismatch_cnt     number of rows where A != B
//   first_mismatch   lowest mismatching minterm index, 0 if there is none
//   equiv            A == B on every row (valid from the DONE cycle onward)
//   const_a          01 = A is constant 0, 10 = A is constant 1, else 00

module minterm_table_scanner #(
  parameter  int N_IN = 2,
  localparam int ROWS = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ROWS-1:0] mask_a,
  input  logic [ROWS-1:0] mask_b,
  output logic            busy,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [N_IN-1:0] row_m,
  output logic            row_fa,
  output logic            row_fb,
  output logic            row_mismatch,
  output logic            done,
  output logic [N_IN:0]   ones_a,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_mismatch,
  output logic            equiv,
  output logic [1:0]      const_a
);

  localparam logic [N_IN-1:0] LAST_ROW   = N_IN'(ROWS - 1);
  localparam logic [N_IN:0]   ROWS_COUNT = (N_IN + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ROWS-1:0] mask_a_q, mask_b_q;
  logic            accept_start;
  logic            transfer;
  logic            last_row;
  logic [N_IN:0]   ones_next;
  logic [N_IN:0]   mismatch_next;

  // Each row's function values come straight out of the latched masks.
  // The mask registers hold steady for the whole scan, so the row outputs
  // stay stable while the consumer stalls.
  assign row_fa       = mask_a_q[row_m];
  assign row_fb       = mask_b_q[row_m];
  assign row_mismatch = row_fa ^ row_fb;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs. DONE
  // always lasts exactly one cycle. A start seen in that cycle is taken
  // just like a start seen in IDLE.
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    row_valid    = 1'b0;
    done         = 1'b0;
    accept_start = 1'b0;
    transfer     = 1'b0;
    last_row     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        transfer  = row_ready;
        last_row  = (row_m == LAST_ROW);
        if (transfer && last_row) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept_start = 1'b1;
          state_d      = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter values after folding in the row that is transferring now.
  always_comb begin
    ones_next     = ones_a + (N_IN + 1)'(row_fa);
    mismatch_next = mismatch_cnt + (N_IN + 1)'(row_mismatch);
  end

  // Datapath: mask capture, row index and result accumulation.
  // On the last row, row_m stays at ROWS-1 instead of wrapping. equiv and
  // const_a are written only then, so they read 0 throughout SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_a_q       <= '0;
      mask_b_q       <= '0;
      row_m          <= '0;
      ones_a         <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
      equiv          <= 1'b0;
      const_a        <= 2'b00;
    end else if (accept_start) begin
      mask_a_q       <= mask_a;
      mask_b_q       <= mask_b;
      row_m          <= '0;
      ones_a         <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
      equiv          <= 1'b0;
      const_a        <= 2'b00;
    end else if (transfer) begin
      ones_a       <= ones_next;
      mismatch_cnt <= mismatch_next;
      // A zero count so far means this is the first mismatching row.
      if (row_mismatch && (mismatch_cnt == '0)) begin
        first_mismatch <= row_m;
      end
      if (last_row) begin
        equiv <= (mismatch_next == '0);
        if (ones_next == ROWS_COUNT) begin
          const_a <= 2'b10;
        end else if (ones_next == '0) begin
          const_a <= 2'b01;
        end else begin
          const_a <= 2'b00;
        end
      end else begin
        row_m <= row_m + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_minterm_table_scanner.sv
// tb_minterm_table_scanner
// ------------------------
// Directed bench for minterm_table_scanner. It uses one instance with
// N_IN=2 for the main scenarios and one with N_IN=3 for the wider
// constant-0 case. Expected truth-table rows go into a queue when a scan
// is started. They are popped and compared as the DUT transfers them.
// Expected results come from a simple reference model of the two masks.

module tb_minterm_table_scanner;

  logic clk;
  logic rst_n;

  // N_IN = 2 instance
  logic       start2;
  logic [3:0] mask_a2, mask_b2;
  logic       busy2, row_valid2, row_ready2;
  logic [1:0] row_m2;
  logic       row_fa2, row_fb2, row_mismatch2, done2;
  logic [2:0] ones_a2, mismatch_cnt2;
  logic [1:0] first_mismatch2;
  logic       equiv2;
  logic [1:0] const_a2;

  // N_IN = 3 instance
  logic       start3;
  logic [7:0] mask_a3, mask_b3;
  logic       busy3, row_valid3, row_ready3;
  logic [2:0] row_m3;
  logic       row_fa3, row_fb3, row_mismatch3, done3;
  logic [3:0] ones_a3, mismatch_cnt3;
  logic [2:0] first_mismatch3;
  logic       equiv3;
  logic [1:0] const_a3;

  typedef struct {
    int   m;
    logic fa;
    logic fb;
    logic mm;
  } row_t;

  row_t row_q[$];

  int tests_run = 0;
  int fail_cnt  = 0;

  int         exp_ones, exp_mm, exp_first, exp_const;
  logic       exp_equiv;
  logic [3:0] cur_ma, cur_mb;

  minterm_table_scanner #(.N_IN(2)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start2),
    .mask_a         (mask_a2),
    .mask_b         (mask_b2),
    .busy           (busy2),
    .row_valid      (row_valid2),
    .row_ready      (row_ready2),
    .row_m          (row_m2),
    .row_fa         (row_fa2),
    .row_fb         (row_fb2),
    .row_mismatch   (row_mismatch2),
    .done           (done2),
    .ones_a         (ones_a2),
    .mismatch_cnt   (mismatch_cnt2),
    .first_mismatch (first_mismatch2),
    .equiv          (equiv2),
    .const_a        (const_a2)
  );

  minterm_table_scanner #(.N_IN(3)) dut3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start3),
    .mask_a         (mask_a3),
    .mask_b         (mask_b3),
    .busy           (busy3),
    .row_valid      (row_valid3),
    .row_ready      (row_ready3),
    .row_m          (row_m3),
    .row_fa         (row_fa3),
    .row_fb         (row_fb3),
    .row_mismatch   (row_mismatch3),
    .done           (done3),
    .ones_a         (ones_a3),
    .mismatch_cnt   (mismatch_cnt3),
    .first_mismatch (first_mismatch3),
    .equiv          (equiv3),
    .const_a        (const_a3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: derives the final results directly from the masks.
  task automatic computeExpected(input logic [255:0] ma, input logic [255:0] mb, input int rows);
    exp_ones  = 0;
    exp_mm    = 0;
    exp_first = 0;
    for (int m = 0; m < rows; m++) begin
      if (ma[m]) exp_ones++;
      if (ma[m] != mb[m]) begin
        if (exp_mm == 0) exp_first = m;
        exp_mm++;
      end
    end
    exp_equiv = (exp_mm == 0);
    exp_const = (exp_ones == rows) ? 2 : ((exp_ones == 0) ? 1 : 0);
  endtask

  // Start a scan on the N_IN=2 instance and queue the rows it should emit.
  task automatic applyStimulus(input logic [3:0] ma, input logic [3:0] mb);
    row_t r;
    cur_ma  = ma;
    cur_mb  = mb;
    mask_a2 = ma;
    mask_b2 = mb;
    start2  = 1'b1;
    row_q.delete();
    for (int m = 0; m < 4; m++) begin
      r.m  = m;
      r.fa = ma[m];
      r.fb = mb[m];
      r.mm = ma[m] ^ mb[m];
      row_q.push_back(r);
    end
    computeExpected(256'(ma), 256'(mb), 4);
    @(posedge clk);
    #1 start2 = 1'b0;
  endtask

  // Consume rows until done. Optionally stall at row stall_m for stall_len
  // cycles, and optionally pulse start with scrambled masks at row ignore_m.
  // Returns at the falling edge of the done cycle.
  task automatic drainScan(input int stall_m, input int stall_len, input int ignore_m,
                           input int exp_cycles);
    int   cycles     = 0;
    int   stall_left = stall_len;
    bit   got_done   = 0;
    bit   poked      = 0;
    bit   restore    = 0;
    row_t r;
    row_ready2 = 1'b1;
    while (!got_done && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (restore) begin
        start2  = 1'b0;
        mask_a2 = cur_ma;
        mask_b2 = cur_mb;
        restore = 0;
      end
      if (done2) begin
        got_done = 1;
      end else if (row_valid2) begin
        if (cycles == 1) begin
          checkOutput("cleared_ones_a", 32'(ones_a2), 32'd0);
          checkOutput("cleared_mismatch_cnt", 32'(mismatch_cnt2), 32'd0);
        end
        checkOutput("scan_busy", 32'(busy2), 32'd1);
        checkOutput("scan_equiv_const_zero", 32'({equiv2, const_a2}), 32'd0);
        checkOutput("row_q_nonempty", 32'(row_q.size() > 0), 32'd1);
        if (row_q.size() > 0) begin
          r = row_q[0];
          checkOutput("row_m", 32'(row_m2), 32'(r.m));
          checkOutput("row_fa", 32'(row_fa2), 32'(r.fa));
          checkOutput("row_fb", 32'(row_fb2), 32'(r.fb));
          checkOutput("row_mismatch", 32'(row_mismatch2), 32'(r.mm));
        end
        if (stall_left > 0 && int'(row_m2) == stall_m) begin
          row_ready2 = 1'b0;
          stall_left--;
        end else begin
          row_ready2 = 1'b1;
          if (row_q.size() > 0) void'(row_q.pop_front());
        end
        if (!poked && int'(row_m2) == ignore_m) begin
          poked   = 1;
          restore = 1;
          start2  = 1'b1;
          mask_a2 = ~cur_ma;
          mask_b2 = ~cur_mb;
        end
      end
    end
    checkOutput("done_seen", 32'(got_done), 32'd1);
    if (got_done) begin
      checkOutput("done_latency", 32'(cycles), 32'(exp_cycles));
      checkOutput("done_busy", 32'(busy2), 32'd0);
      checkOutput("done_row_valid", 32'(row_valid2), 32'd0);
      checkOutput("rows_all_transferred", 32'(row_q.size()), 32'd0);
      checkOutput("ones_a", 32'(ones_a2), 32'(exp_ones));
      checkOutput("mismatch_cnt", 32'(mismatch_cnt2), 32'(exp_mm));
      checkOutput("first_mismatch", 32'(first_mismatch2), 32'(exp_first));
      checkOutput("equiv", 32'(equiv2), 32'(exp_equiv));
      checkOutput("const_a", 32'(const_a2), 32'(exp_const));
    end
  endtask

  // Directed sequence of scenarios.
  initial begin
    int rows3;
    int cyc;
    bit seen;

    rst_n      = 1'b0;
    start2     = 1'b0;
    mask_a2    = '0;
    mask_b2    = '0;
    row_ready2 = 1'b1;
    start3     = 1'b0;
    mask_a3    = '0;
    mask_b3    = '0;
    row_ready3 = 1'b1;
    cur_ma     = '0;
    cur_mb     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy2), 32'd0);
    checkOutput("rst_row_valid", 32'(row_valid2), 32'd0);
    checkOutput("rst_done", 32'(done2), 32'd0);
    checkOutput("rst_row_m", 32'(row_m2), 32'd0);
    checkOutput("rst_row_fa_fb", 32'({row_fa2, row_fb2}), 32'd0);
    checkOutput("rst_results",
                32'({ones_a2, mismatch_cnt2, first_mismatch2, equiv2, const_a2}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identical constant-1 functions
    applyStimulus(4'b1111, 4'b1111);
    drainScan(-1, 0, -1, 5);
    @(negedge clk);
    checkOutput("hold_ones_a", 32'(ones_a2), 32'd4);
    checkOutput("hold_equiv", 32'(equiv2), 32'd1);
    checkOutput("hold_done_low", 32'(done2), 32'd0);

    // XOR versus OR: differs only at m=3
    applyStimulus(4'b0110, 4'b1110);
    drainScan(-1, 0, -1, 5);

    // Backpressure: three stalled cycles at m=1
    applyStimulus(4'b0110, 4'b1110);
    drainScan(1, 3, -1, 8);

    // start pulsed at m=2 with different masks is ignored
    applyStimulus(4'b1010, 4'b0011);
    drainScan(-1, 0, 2, 5);
    // start in the DONE cycle launches a fresh scan with cleared counters
    applyStimulus(4'b0001, 4'b1000);
    drainScan(-1, 0, -1, 5);

    // Reset in the middle of a scan
    applyStimulus(4'b1111, 4'b0000);
    row_ready2 = 1'b1;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (row_valid2 && row_m2 == 2'd2) seen = 1;
    end
    checkOutput("midscan_reached_m2", 32'(seen), 32'd1);
    checkOutput("midscan_ones_before_reset", 32'(ones_a2), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy2), 32'd0);
    checkOutput("midrst_row_valid", 32'(row_valid2), 32'd0);
    checkOutput("midrst_row_m", 32'(row_m2), 32'd0);
    checkOutput("midrst_counters",
                32'({ones_a2, mismatch_cnt2, first_mismatch2}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("midrst_no_done", 32'(done2), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'b1111, 4'b0000);
    drainScan(-1, 0, -1, 5);

    // N_IN = 3: A constant 0, B = minterm 0 only
    computeExpected(256'(8'h00), 256'(8'h01), 8);
    mask_a3 = 8'h00;
    mask_b3 = 8'h01;
    start3  = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    rows3 = 0;
    cyc   = 0;
    seen  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done3) seen = 1;
      else if (row_valid3 && row_ready3) begin
        if (row_m3 == 3'd0) checkOutput("n3_row0_mismatch", 32'(row_mismatch3), 32'd1);
        rows3++;
      end
    end
    checkOutput("n3_done_seen", 32'(seen), 32'd1);
    checkOutput("n3_rows", 32'(rows3), 32'd8);
    checkOutput("n3_ones_a", 32'(ones_a3), 32'(exp_ones));
    checkOutput("n3_const_a", 32'(const_a3), 32'(exp_const));
    checkOutput("n3_mismatch_cnt", 32'(mismatch_cnt3), 32'(exp_mm));
    checkOutput("n3_first_mismatch", 32'(first_mismatch3), 32'(exp_first));
    checkOutput("n3_equiv", 32'(equiv3), 32'(exp_equiv));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
